// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port (A = ALU, B = load/multi-cycle); drops writes to $zero.
// Latency: 0-cycle grant (ready is combinational), 1-cycle registered write.
// Backpressure: the losing requester sees ready = 0 and holds; flush stalls both; the write port itself never stalls.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              flush,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_src,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    logic    prio;
    logic    a_grant;
    logic    b_grant;
    logic    grant;
    logic    contest;
    wb_req_t sel_req;

    always_comb begin
        contest = a_valid && b_valid && !flush;
        a_grant = a_valid && !flush && (!b_valid || !prio);
        b_grant = b_valid && !flush && (!a_valid || prio);
        grant   = a_grant || b_grant;
        sel_req = b_grant ? wb_req_t'{addr: b_addr, data: b_data}
                          : wb_req_t'{addr: a_addr, data: a_data};
    end

    assign a_ready = a_grant;
    assign b_ready = b_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio         <= 1'b0;
            wb_en        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            wb_src       <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            // $zero writes are still accepted upstream, just never enabled here
            wb_en <= grant && (sel_req.addr != '0);
            if (grant) begin
                wb_addr <= sel_req.addr;
                wb_data <= sel_req.data;
                wb_src  <= b_grant;
                prio    <= a_grant;
            end
            if (contest && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between two write-back requesters: requester A (ALU results) and requester B (load / multi-cycle unit results). Each cycle it grants at most one request, using round-robin arbitration when both request. It registers the winning 5-bit destination address and data into the write-port stage. It replaces the static rt/rd destination select as the final writer of regfile address/data and suppresses writes to register $zero.

## Interface
Parameters:
- DATA_W, 32, write-back data width
- ADDR_W, 5, register address width
- CNT_W, 8, width of the saturating contention counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- a_valid  input  1  requester A has a write-back pending
- a_addr  input  ADDR_W  A destination register
- a_data  input  DATA_W  A write data
- a_ready  output  1  A request accepted this cycle (combinational)
- b_valid  input  1  requester B has a write-back pending
- b_addr  input  ADDR_W  B destination register
- b_data  input  DATA_W  B write data
- b_ready  output  1  B request accepted this cycle (combinational)
- flush  input  1  synchronous squash: no grants this cycle
- wb_en  output  1  regfile write enable (registered)
- wb_addr  output  ADDR_W  regfile write address (registered)
- wb_data  output  DATA_W  regfile write data (registered)
- wb_src  output  1  source of current write: 0 = A, 1 = B (registered)
- conflict_cnt  output  CNT_W  count of contested cycles, saturating

## Operation
- Handshake: a request transfers in any cycle where valid && ready. A requester holds valid, addr and data stable until that cycle. Ready never depends on the regfile; the write port always accepts.
- Priority pointer `prio` is a 1-bit register, 0 = A favoured. Reset value is 0.
- Grant rules:
  - flush = 1: both readies are 0, nothing is granted, and `prio` is unchanged.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by `prio` is granted and the other gets ready = 0.
  - Neither valid: no grant.
- Pointer update: on every grant, `prio` moves to the non-granted requester (A granted gives prio = 1; B granted gives prio = 0). With no grant, `prio` holds.
- Output stage, on the clock edge after a grant:
  - wb_addr and wb_data take the granted addr/data.
  - wb_src takes the granted requester.
  - wb_en = 1 if the granted addr is nonzero, otherwise 0. A write to $zero is still accepted (ready = 1) but is never written.
- Output stage with no grant: wb_en = 0, and wb_addr, wb_data and wb_src hold their previous values.
- Same destination from both requesters in one cycle: no special handling. The writes issue in grant order, so the later write wins in the regfile.
- conflict_cnt increments by 1 in every cycle with a_valid && b_valid && !flush, and saturates at 2^CNT_W − 1.

## Timing
- Grant latency is 0 cycles: ready is combinational from valid, prio and flush.
- Write latency is 1 cycle: accept at edge N, so wb_en/addr/data are valid for the cycle after edge N.
- Throughput is one write per cycle.
- Contention bound: with both held valid continuously, a requester waits at most 1 cycle for a grant.
- Reset values: wb_en = 0, wb_addr = 0, wb_data = 0, wb_src = 0, prio = 0, conflict_cnt = 0. The readies then follow the valids (A wins the first contest).
- Reset asserted mid-operation:
  - All registers clear immediately, so any in-flight wb_en drops asynchronously.
  - A request that was not yet handshaken stays pending at the requester and is granted after rst_n rises, under the reset-state pointer.
- flush concurrent with both valid: no grant, conflict_cnt unchanged, and the next cycle has wb_en = 0.

## Test plan
- Reset then single A: rst_n low → all outputs 0. After release, A valid with addr=8, data=0xDEADBEEF → a_ready=1 the same cycle; next cycle wb_en=1, wb_addr=8, wb_data=0xDEADBEEF, wb_src=0.
- Contention alternation: A (addr=3) and B (addr=4) held valid for 4 cycles → grants in order A, B, A, B; wb_src sequence 0,1,0,1; conflict_cnt=4.
- $zero suppression: B valid with addr=0, data=0x1234 → b_ready=1; next cycle wb_en=0 and wb_src=1.
- Same-address collision: both valid with addr=9, A data=1, B data=2, prio=0 → wb writes 1 then 2 on consecutive cycles; each requester handshakes exactly once.
- Flush: both valid with flush=1 for 2 cycles → both readies 0, wb_en 0, prio and conflict_cnt unchanged. Releasing flush → the prio-selected requester is granted first.
- Async reset mid-stream: assert rst_n between clock edges while wb_en=1 → wb_en drops before the next edge. The held B request is granted on the first edge after release; conflict_cnt saturation is checked separately by forcing 300 contested cycles → conflict_cnt=255.
